// File: rtl/loop_stack_controller.sv
// Nested hardware-loop sequencer: a stack of {count, iter, pc} entries that turns
// decoder loop-begin/loop-end events into registered jump/exit pulses for fetch.
module loop_stack_controller #(
    parameter int BITS      = 18,
    parameter int ADDR_BITS = 16,
    parameter int MAX_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_valid,
    input  logic [BITS-1:0]                    start_count,
    input  logic [ADDR_BITS-1:0]               start_pc,
    input  logic                               end_valid,
    output logic                               jump_valid,
    output logic [ADDR_BITS-1:0]               jump_target,
    output logic                               loop_exit,
    output logic [$clog2(MAX_DEPTH+1)-1:0]     depth,
    output logic [BITS-1:0]                    inner_iteration,
    output logic                               err_overflow,
    output logic                               err_underflow,
    output logic                               err_zero,
    output logic                               err_collision
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int IDX_W   = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    logic [BITS-1:0]      cnt_q  [MAX_DEPTH];
    logic [BITS-1:0]      iter_q [MAX_DEPTH];
    logic [ADDR_BITS-1:0] pc_q   [MAX_DEPTH];
    logic [DEPTH_W-1:0]   depth_q;

    logic                 jump_vld_p1;
    logic                 exit_vld_p1;
    logic [ADDR_BITS-1:0] jump_target_p1;

    logic                 is_empty;
    logic                 is_full;
    logic [IDX_W-1:0]     top_idx;
    logic [IDX_W-1:0]     push_idx;
    logic [BITS-1:0]      top_cnt;
    logic [BITS-1:0]      top_iter;
    logic [ADDR_BITS-1:0] top_pc;
    logic                 end_ok;
    logic                 repeat_loop;
    logic                 pop_loop;
    logic                 do_push;

    // Widened by one bit so a trip count of all-ones cannot wrap the compare.
    function automatic logic has_next(input logic [BITS-1:0] iter, input logic [BITS-1:0] cnt);
        logic [BITS:0] nxt;
        nxt = {1'b0, iter} + (BITS+1)'(1);
        return nxt < {1'b0, cnt};
    endfunction

    always_comb begin
        is_empty = (depth_q == '0);
        is_full  = (depth_q == DEPTH_W'(MAX_DEPTH));
        top_idx  = IDX_W'(depth_q - DEPTH_W'(1));
        push_idx = IDX_W'(depth_q);
        top_cnt  = '0;
        top_iter = '0;
        top_pc   = '0;
        if (!is_empty) begin
            top_cnt  = cnt_q[top_idx];
            top_iter = iter_q[top_idx];
            top_pc   = pc_q[top_idx];
        end
    end

    // A colliding start is dropped; the end is always the one that gets serviced.
    always_comb begin
        end_ok      = end_valid && !is_empty;
        repeat_loop = end_ok && has_next(top_iter, top_cnt);
        pop_loop    = end_ok && !has_next(top_iter, top_cnt);
        do_push     = start_valid && !end_valid && !is_full && (start_count != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
            for (int i = 0; i < MAX_DEPTH; i++) begin
                cnt_q[i]  <= '0;
                iter_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            if (repeat_loop) begin
                iter_q[top_idx] <= top_iter + BITS'(1);
            end
            if (pop_loop) begin
                depth_q <= depth_q - DEPTH_W'(1);
            end else if (do_push) begin
                cnt_q[push_idx]  <= start_count;
                iter_q[push_idx] <= '0;
                pc_q[push_idx]   <= start_pc;
                depth_q          <= depth_q + DEPTH_W'(1);
            end
        end
    end

    // Stage p1: registered redirect/exit pulses, one cycle after end_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jump_vld_p1    <= 1'b0;
            exit_vld_p1    <= 1'b0;
            jump_target_p1 <= '0;
        end else begin
            jump_vld_p1 <= repeat_loop;
            exit_vld_p1 <= pop_loop;
            if (repeat_loop) begin
                jump_target_p1 <= top_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_zero      <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            if (end_valid && is_empty) begin
                err_underflow <= 1'b1;
            end
            if (start_valid && end_valid) begin
                err_collision <= 1'b1;
            end
            if (start_valid && !end_valid) begin
                if (start_count == '0) begin
                    err_zero <= 1'b1;
                end else if (is_full) begin
                    err_overflow <= 1'b1;
                end
            end
        end
    end

    assign jump_valid      = jump_vld_p1;
    assign loop_exit       = exit_vld_p1;
    assign jump_target     = jump_target_p1;
    assign depth           = depth_q;
    assign inner_iteration = top_iter;

endmodule

// File: tb/tb_loop_stack_controller.sv
// Scoreboard bench for loop_stack_controller: stimulus queues expected pulses,
// a negedge monitor pops and compares them against jump_valid/loop_exit.
module tb_loop_stack_controller;

    localparam int BITS      = 12;
    localparam int ADDR_BITS = 16;
    localparam int MAX_DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start_valid;
    logic [BITS-1:0]      start_count;
    logic [ADDR_BITS-1:0] start_pc;
    logic                 end_valid;
    logic                 jump_valid;
    logic [ADDR_BITS-1:0] jump_target;
    logic                 loop_exit;
    logic [2:0]           depth;
    logic [BITS-1:0]      inner_iteration;
    logic                 err_overflow;
    logic                 err_underflow;
    logic                 err_zero;
    logic                 err_collision;

    loop_stack_controller #(
        .BITS(BITS), .ADDR_BITS(ADDR_BITS), .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_count(start_count), .start_pc(start_pc),
        .end_valid(end_valid),
        .jump_valid(jump_valid), .jump_target(jump_target), .loop_exit(loop_exit),
        .depth(depth), .inner_iteration(inner_iteration),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
        .err_zero(err_zero), .err_collision(err_collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit j;
        bit x;
        int t;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   last_tgt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (jump_valid || loop_exit) begin
            if (q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL spurious_pulse: got jump=%0b exit=%0b expected no pulse (cycle %0d)",
                         jump_valid, loop_exit, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("jump_valid", int'(jump_valid), int'(e.j));
                chk("loop_exit", int'(loop_exit), int'(e.x));
                chk("jump_target", int'(jump_target), e.t);
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            nvec++;
            nerr++;
            $display("FAIL missing_pulse: got none expected jump=%0b exit=%0b at cycle %0d",
                     e.j, e.x, e.cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int cnt, input int pc);
        start_valid = 1'b1;
        start_count = BITS'(cnt);
        start_pc    = ADDR_BITS'(pc);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic do_end(input bit j, input int tgt);
        exp_t e;
        e.cyc = cyc + 1;
        e.j   = j;
        e.x   = !j;
        if (j) last_tgt = tgt;
        e.t   = last_tgt;
        q.push_back(e);
        end_valid = 1'b1;
        @(negedge clk);
        end_valid = 1'b0;
    endtask

    task automatic end_none();
        end_valid = 1'b1;
        @(negedge clk);
        end_valid = 1'b0;
    endtask

    task automatic chk_errs(input string name, input int ov, input int un, input int z, input int col);
        chk({name, "_ovf"}, int'(err_overflow), ov);
        chk({name, "_unf"}, int'(err_underflow), un);
        chk({name, "_zero"}, int'(err_zero), z);
        chk({name, "_coll"}, int'(err_collision), col);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_depth", int'(depth), 0);
        chk("rst_target", int'(jump_target), 0);
        chk("rst_iter", int'(inner_iteration), 0);
        chk_errs("rst", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        last_tgt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start_valid = 1'b0;
        start_count = '0;
        start_pc = '0;
        end_valid = 1'b0;
        idle(2);
        chk("init_depth", int'(depth), 0);
        chk("init_jump", int'(jump_valid), 0);
        chk("init_exit", int'(loop_exit), 0);
        chk("init_target", int'(jump_target), 0);
        chk("init_iter", int'(inner_iteration), 0);
        chk_errs("init", 0, 0, 0, 0);
        reset = 1'b0;
        idle(1);

        // Single loop of three iterations.
        push(3, 'h40);
        chk("s_depth0", int'(depth), 1);
        chk("s_iter0", int'(inner_iteration), 0);
        do_end(1, 'h40);
        chk("s_iter1", int'(inner_iteration), 1);
        idle(3);
        do_end(1, 'h40);
        chk("s_iter2", int'(inner_iteration), 2);
        idle(3);
        do_end(0, 0);
        chk("s_depth_end", int'(depth), 0);
        chk("s_iter_end", int'(inner_iteration), 0);
        idle(2);

        // Nested: outer (2,0x10), inner (3,0x20), re-pushed after the outer jump.
        push(2, 'h10);
        push(3, 'h20);
        chk("n_depth_a", int'(depth), 2);
        do_end(1, 'h20);
        chk("n_depth_1", int'(depth), 2);
        do_end(1, 'h20);
        chk("n_depth_2", int'(depth), 2);
        do_end(0, 0);
        chk("n_depth_3", int'(depth), 1);
        chk("n_outer_iter", int'(inner_iteration), 0);
        do_end(1, 'h10);
        chk("n_outer_iter1", int'(inner_iteration), 1);
        push(3, 'h20);
        chk("n_depth_re", int'(depth), 2);
        chk("n_iter_re", int'(inner_iteration), 0);
        do_end(1, 'h20);
        do_end(1, 'h20);
        do_end(0, 0);
        chk("n_depth_7", int'(depth), 1);
        do_end(0, 0);
        chk("n_depth_8", int'(depth), 0);
        chk_errs("nest", 0, 0, 0, 0);
        idle(2);

        // Errors: underflow, zero count at full (precedence), overflow, sticky.
        end_none();
        chk("e_unf_depth", int'(depth), 0);
        chk_errs("e_unf", 0, 1, 0, 0);
        push(5, 'h1);
        push(5, 'h2);
        push(5, 'h3);
        push(5, 'h4);
        chk("e_full_depth", int'(depth), 4);
        push(0, 'h9);
        chk("e_zero_depth", int'(depth), 4);
        chk_errs("e_zero", 0, 1, 1, 0);
        push(5, 'h9);
        chk("e_ovf_depth", int'(depth), 4);
        chk_errs("e_ovf", 1, 1, 1, 0);
        do_end(1, 'h4);
        chk("e_after_iter", int'(inner_iteration), 1);
        idle(3);
        chk_errs("e_sticky", 1, 1, 1, 0);
        do_reset();

        // Collision: end wins, start dropped.
        push(2, 'h55);
        start_valid = 1'b1;
        start_count = BITS'(7);
        start_pc    = ADDR_BITS'('h99);
        do_end(1, 'h55);
        start_valid = 1'b0;
        chk("c_depth", int'(depth), 1);
        chk("c_iter", int'(inner_iteration), 1);
        chk_errs("c", 0, 0, 0, 1);
        do_end(0, 0);
        chk("c_depth_end", int'(depth), 0);
        idle(2);
        do_reset();

        // Asynchronous reset between edges while an end is pending.
        push(4, 'h100);
        push(4, 'h200);
        push(4, 'h300);
        do_end(1, 'h300);
        push(0, 'h0);
        chk("m_depth", int'(depth), 3);
        chk("m_zero", int'(err_zero), 1);
        end_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("m_depth_now", int'(depth), 0);
        chk("m_target_now", int'(jump_target), 0);
        chk("m_iter_now", int'(inner_iteration), 0);
        chk("m_zero_now", int'(err_zero), 0);
        @(negedge clk);
        end_valid = 1'b0;
        chk("m_jump_hold", int'(jump_valid), 0);
        reset = 1'b0;
        last_tgt = 0;
        @(negedge clk);
        chk("m_jump_after", int'(jump_valid), 0);
        chk("m_depth_after", int'(depth), 0);
        chk_errs("m", 0, 0, 0, 0);

        // Full-range trip count, ends back-to-back.
        push((1 << BITS) - 1, 'h7ff);
        for (int i = 0; i < (1 << BITS) - 2; i++) begin
            do_end(1, 'h7ff);
            chk("w_iter", int'(inner_iteration), i + 1);
        end
        do_end(0, 0);
        chk("w_depth", int'(depth), 0);
        chk("w_iter_end", int'(inner_iteration), 0);

        idle(3);
        chk("sb_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
